// File: rtl/sr_pkg.sv
// Shared encodings and op resolution for the SR command sequencer.
// Used by the top and the bench.
package sr_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_SET    = 2'b01,
    OP_RESET  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_GAP   = 2'b10
  } st_e;

  // s/r: drive pattern; upd: model changes; q: new model value
  typedef struct packed {
    logic s;
    logic r;
    logic upd;
    logic q;
  } drv_t;

  function automatic drv_t resolve(op_e op, logic qexp, logic qvalid);
    drv_t d;
    d = '0;
    unique case (op)
      OP_SET: begin
        d.s   = 1'b1;
        d.upd = 1'b1;
        d.q   = 1'b1;
      end
      OP_RESET: begin
        d.r   = 1'b1;
        d.upd = 1'b1;
      end
      OP_TOGGLE: begin
        if (qvalid) begin
          d.s   = ~qexp;
          d.r   = qexp;
          d.upd = 1'b1;
          d.q   = ~qexp;
        end
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Command, drive and feedback bundle of the SR sequencer.
// slave = sequencer, master = command source / flip-flop side.
interface sr_cmd_sequencer_if;
  logic [1:0] OP;
  logic       PUSH;
  logic       FULL;
  logic       EMPTY;
  logic       S;
  logic       R;
  logic       Q;
  logic       Qbar;
  logic       BUSY;
  logic       QEXP;
  logic       QVALID;
  logic       ERR;
  logic       OVF;
  logic [3:0] ERRCNT;

  modport master (
    output OP, PUSH, Q, Qbar,
    input  FULL, EMPTY, S, R, BUSY,
    input  QEXP, QVALID, ERR, OVF, ERRCNT
  );

  modport slave (
    input  OP, PUSH, Q, Qbar,
    output FULL, EMPTY, S, R, BUSY,
    output QEXP, QVALID, ERR, OVF, ERRCNT
  );
endinterface

// File: rtl/cmd_fifo.sv
// Small command FIFO, falling-edge clocked, async clear.
// Push while full is accepted only with a same-edge pop.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         C,
  input  logic         CLR,
  input  logic         PUSH,
  input  logic         POP,
  input  logic [W-1:0] DIN,
  output logic [W-1:0] DOUT,
  output logic         FULL,
  output logic         EMPTY
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] NFULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign FULL    = (cnt == NFULL);
  assign EMPTY   = (cnt == '0);
  assign do_pop  = POP && !EMPTY;
  assign do_push = PUSH && (!FULL || do_pop);
  assign DOUT    = mem[rd];

  // storage write, no reset needed
  always_ff @(negedge C) begin
    if (do_push) mem[wr] <= DIN;
  end

  // pointers wrap naturally, count tracks occupancy
  always_ff @(negedge C or posedge CLR) begin
    if (CLR) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop)  rd <= rd + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns queued HOLD/SET/RESET/TOGGLE commands into timed S/R drives
// and checks the fed-back flip-flop outputs against a state model.
module sr_cmd_sequencer
  import sr_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 1,
  parameter int GAP_CYC  = 1
) (
  input logic               C,
  input logic               CLR,
  sr_cmd_sequencer_if.slave bus
);
  localparam logic [3:0] HLD = 4'(HOLD_CYC - 1);
  localparam logic [3:0] GP  = 4'(GAP_CYC - 1);

  st_e        st;
  logic [3:0] cnt;
  logic       s, r;
  logic       qexp, qvalid;
  logic       err, ovf;
  logic [3:0] errcnt;
  logic [1:0] head;
  logic       full, empty;
  logic       pop;
  logic       chk;
  drv_t       drv;

  cmd_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
    .C     (C),
    .CLR   (CLR),
    .PUSH  (bus.PUSH),
    .POP   (pop),
    .DIN   (bus.OP),
    .DOUT  (head),
    .FULL  (full),
    .EMPTY (empty)
  );

  assign pop = !empty &&
               ((st == ST_IDLE) ||
                (st == ST_GAP && cnt == 4'd0));
  assign drv = resolve(op_e'(head), qexp, qvalid);
  assign chk = (st == ST_GAP) && (cnt == GP) && qvalid &&
               ((bus.Q != qexp) || (bus.Q == bus.Qbar));

  assign bus.S      = s;
  assign bus.R      = r;
  assign bus.FULL   = full;
  assign bus.EMPTY  = empty;
  assign bus.BUSY   = (st != ST_IDLE);
  assign bus.QEXP   = qexp;
  assign bus.QVALID = qvalid;
  assign bus.ERR    = err;
  assign bus.OVF    = ovf;
  assign bus.ERRCNT = errcnt;

  // sequencer FSM, model and checker; S/R move only on falling C
  always_ff @(negedge C or posedge CLR) begin
    if (CLR) begin
      st     <= ST_IDLE;
      cnt    <= 4'd0;
      s      <= 1'b0;
      r      <= 1'b0;
      qexp   <= 1'b0;
      qvalid <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
      errcnt <= 4'd0;
    end else begin
      err <= chk;
      if (chk && errcnt != 4'hF) errcnt <= errcnt + 4'd1;
      if (bus.PUSH && full && !pop) ovf <= 1'b1;
      if (pop) begin
        s   <= drv.s;
        r   <= drv.r;
        cnt <= HLD;
        st  <= ST_DRIVE;
        if (drv.upd) begin
          qexp   <= drv.q;
          qvalid <= 1'b1;
        end
      end else begin
        unique case (st)
          ST_DRIVE: begin
            if (cnt == 4'd0) begin
              s   <= 1'b0;
              r   <= 1'b0;
              cnt <= GP;
              st  <= ST_GAP;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_GAP: begin
            if (cnt == 4'd0) st <= ST_IDLE;
            else cnt <= cnt - 4'd1;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/sr_cmd_sequencer.md
Name: sr_cmd_sequencer

Overview:
- Upstream driver stage for the master-slave SR flip-flop.
- Accepts queued high-level commands (HOLD, SET, RESET, TOGGLE) and converts each into a legal S/R drive pattern held for a fixed number of clock cycles.
- Never drives the forbidden S=R=1 pair.
- Keeps a model of the expected flip-flop state and checks the flip-flop's fed-back Q/Qbar against it, flagging mismatches.

Parameters:
- DEPTH, 4, command queue entries; power of two, 2..16.
- HOLD_CYC, 1, cycles each S/R pattern is driven; 1..15.
- GAP_CYC, 1, cycles of S=R=0 after each drive; 1..15 (0 illegal).

Ports:
- C  input  1  clock; all state updates on the falling edge of C.
- CLR  input  1  asynchronous active-high reset.
- OP  input  2  command: 00 HOLD, 01 SET, 10 RESET, 11 TOGGLE.
- PUSH  input  1  enqueue OP on this falling edge.
- FULL  output  1  queue holds DEPTH entries.
- EMPTY  output  1  queue holds 0 entries.
- S  output  1  set drive to the flip-flop.
- R  output  1  reset drive to the flip-flop.
- Q  input  1  flip-flop true output (feedback).
- Qbar  input  1  flip-flop complement output (feedback).
- BUSY  output  1  state is not IDLE.
- QEXP  output  1  modelled flip-flop state.
- QVALID  output  1  QEXP is known.
- ERR  output  1  one-cycle pulse on a check failure.
- OVF  output  1  sticky: a PUSH was dropped.
- ERRCNT  output  4  saturating count of check failures.

Behaviour:
- Falling-edge clocking is mandatory: S/R then change only on the falling edge and are stable for the whole high phase, while the master latch is transparent.
- Reset (CLR=1, asynchronous) forces:
  - S=0, R=0, state IDLE, queue empty (EMPTY=1, FULL=0);
  - QEXP=0, QVALID=0, ERR=0, OVF=0, ERRCNT=0.
- Queue: FIFO with a read pointer, a write pointer and a count.
  - Both pointers wrap modulo DEPTH.
  - PUSH while FULL with no pop on the same edge: entry dropped, OVF set, held until CLR.
  - PUSH and pop on the same edge while FULL: accepted; count unchanged.
- FSM states are IDLE, DRIVE and GAP.
- IDLE:
  - S=R=0.
  - If the queue is non-empty: pop the head, resolve the op, load the hold counter with HOLD_CYC-1, go to DRIVE.
  - The pop and the S/R update happen on the same edge.
- Op resolution:
  - SET gives S=1, R=0; then QEXP=1, QVALID=1.
  - RESET gives S=0, R=1; then QEXP=0, QVALID=1.
  - HOLD gives S=0, R=0; QEXP and QVALID unchanged.
  - TOGGLE with QVALID=1: drive SET if QEXP=0, RESET if QEXP=1; QEXP inverts.
  - TOGGLE with QVALID=0: driven as HOLD, no model change.
  - QEXP/QVALID update on the same edge the drive starts.
- DRIVE:
  - Hold S/R until the counter reaches 0.
  - Then set S=R=0, load the counter with GAP_CYC-1, go to GAP.
- GAP:
  - S=R=0.
  - Check: on the falling edge that ends the first GAP cycle, if QVALID=1 and (Q!=QEXP or Q==Qbar), pulse ERR for one cycle and increment ERRCNT, saturating at 15.
  - No check is made when QVALID=0.
  - At the end of the last GAP cycle: if the queue is non-empty, pop and go directly to DRIVE (back-to-back, no IDLE cycle); else go to IDLE.
- Latency:
  - A PUSH into an empty, IDLE block drives S/R on the next falling edge.
  - One command occupies HOLD_CYC+GAP_CYC cycles.
- Invariant: S&R is 0 at all times, including during reset.
- Reset mid-operation: S/R drop to 0 immediately (asynchronously); queued commands are lost.

Decomposition:
- Shared package sr_pkg holds:
  - the op encodings OP_HOLD, OP_SET, OP_RESET, OP_TOGGLE;
  - the FSM state encodings ST_IDLE, ST_DRIVE, ST_GAP.
- One natural sub-module: cmd_fifo (parameterised DEPTH, width 2; ports PUSH/POP/DIN/DOUT/FULL/EMPTY).
- The FSM, op resolution, model and checker stay in the top.

Test Plan:
- Reset, defaults (HOLD_CYC=1, GAP_CYC=1): assert CLR mid-cycle -> S=R=0, EMPTY=1, QVALID=0, ERRCNT=0 immediately. Release; push SET -> S=1 for exactly one cycle, then 0; QEXP=1, QVALID=1; with Q=1/Qbar=0 fed back, no ERR.
- Push SET, TOGGLE, TOGGLE, RESET back-to-back -> S/R sequence (1,0),(0,0),(0,1),(0,0),(1,0),(0,0),(0,1),(0,0); QEXP 1,0,1,0; BUSY high throughout; no IDLE cycle between commands.
- Right after reset, push TOGGLE -> S=R=0, QVALID stays 0, no ERR even with Q=Qbar=1.
- Push 5 commands with DEPTH=4 while the head is executing -> FULL=1, fifth dropped, OVF=1; exactly 4 queued commands executed.
- After SET, force Q=0/Qbar=1 -> ERR pulses one cycle at the end of the first GAP cycle, ERRCNT=1. Force Q=Qbar=1 over 16 checks -> ERRCNT saturates at 15.
- HOLD_CYC=3, GAP_CYC=2, push RESET -> R=1 for 3 cycles then S=R=0 for 2 cycles; a check at every edge asserts S&R never 1.
